dma_arbiter: RTL and testbench

Round-robin arbiter sharing the single auxiliary DMA port between the CSB command fetch and the compute engines (CONV1x1, CONV3x3, POOL3x3/13x13). It grants one requester at a time, issues exactly one burst descriptor to the DMA engine on that requester's behalf, and holds the grant until the burst completes. It sits between the CSB/submodule DMA request lines and the SDRAM DMA front end.

---
 rtl/dma_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_dma_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// dma_arbiter: round-robin arbiter that shares one auxiliary DMA port between
// the CSB command fetch (0) and the compute engines (1..NREQ-1). The granted
// requester's descriptor is latched, issued once, and the grant is held until
// the burst completes.
// Optional feature: define DMA_ARB_TIMEOUT_EN to enable a watchdog that aborts
// a burst stuck in ISSUE/BUSY for TIMEOUT cycles and pulses err.
module dma_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int LW      = 6,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*LW-1:0]   req_len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 dma_en,
    input  logic                 dma_rdy,
    output logic                 dma_we,
    output logic [AW-1:0]        dma_addr,
    output logic [LW-1:0]        dma_len,
    input  logic                 dma_done,
    output logic                 busy,
    output logic                 err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     cur_q, cur_d;
    logic              imm_q, imm_d;
    logic              dma_we_q, dma_we_d;
    logic [AW-1:0]     dma_addr_q, dma_addr_d;
    logic [LW-1:0]     dma_len_q, dma_len_d;
    logic              finish;

    // Per-requester views of the packed buses, and the requester index that
    // sits at each priority position relative to the round-robin pointer.
    logic [AW-1:0]     addr_arr [NREQ];
    logic [LW-1:0]     len_arr  [NREQ];
    logic [PW-1:0]     rot_idx  [NREQ];
    logic [NREQ-1:0]   cand_ok;
    logic [PW-1:0]     sel_idx;
    logic              sel_valid;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign addr_arr[gi] = req_addr[gi*AW +: AW];
        assign len_arr[gi]  = req_len[gi*LW +: LW];
        assign rot_idx[gi]  = PW'((int'(ptr_q) + gi) % NREQ);
        assign cand_ok[gi]  = req[rot_idx[gi]];
    end

    // Pick the first requesting lane at or after ptr; position 0 has top priority.
    always_comb begin
        sel_idx   = rot_idx[0];
        sel_valid = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_ok[k]) begin
                sel_idx = rot_idx[k];
            end
        end
    end

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // Next-state and next-output logic for the IDLE/ISSUE/BUSY controller.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        ptr_d      = ptr_q;
        cur_d      = cur_q;
        imm_d      = imm_q;
        dma_we_d   = dma_we_q;
        dma_addr_d = dma_addr_q;
        dma_len_d  = dma_len_q;
        finish     = 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (sel_valid) begin
                    gnt_d      = NREQ'(1) << sel_idx;
                    cur_d      = sel_idx;
                    dma_we_d   = req_we[sel_idx];
                    dma_addr_d = addr_arr[sel_idx];
                    dma_len_d  = len_arr[sel_idx];
                    // A zero-length burst completes without touching the DMA engine.
                    imm_d      = (len_arr[sel_idx] == '0);
                    state_d    = (len_arr[sel_idx] == '0) ? S_BUSY : S_ISSUE;
`ifdef DMA_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            S_ISSUE: begin
                if (dma_rdy) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (dma_done || imm_q) begin
                    finish = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef DMA_ARB_TIMEOUT_EN
        // Watchdog: a real completion in the same cycle wins over the timeout.
        if (state_q != S_IDLE) begin
            cnt_d = cnt_q + 1'b1;
            if (!finish && cnt_q == CW'(TIMEOUT - 1)) begin
                finish = 1'b1;
                err_d  = 1'b1;
            end
        end
`endif
        if (finish) begin
            done_d  = gnt_q;
            gnt_d   = '0;
            imm_d   = 1'b0;
            ptr_d   = (cur_q == PW'(NREQ - 1)) ? '0 : cur_q + 1'b1;
            state_d = S_IDLE;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            ptr_q      <= '0;
            cur_q      <= '0;
            imm_q      <= 1'b0;
            dma_we_q   <= 1'b0;
            dma_addr_q <= '0;
            dma_len_q  <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            ptr_q      <= ptr_d;
            cur_q      <= cur_d;
            imm_q      <= imm_d;
            dma_we_q   <= dma_we_d;
            dma_addr_q <= dma_addr_d;
            dma_len_q  <= dma_len_d;
`ifdef DMA_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign dma_en   = (state_q == S_ISSUE);
    assign dma_we   = dma_we_q;
    assign dma_addr = dma_addr_q;
    assign dma_len  = dma_len_q;
    assign busy     = (state_q != S_IDLE);
`ifdef DMA_ARB_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: reset state, single burst, round-robin
// rotation, descriptor stall, zero-length burst, reset mid-burst, and the
// watchdog when DMA_ARB_TIMEOUT_EN is defined (TIMEOUT = 20).
module tb_dma_arbiter;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [3:0]    req_we;
    logic [127:0]  req_addr;
    logic [23:0]   req_len;
    logic [3:0]    gnt;
    logic [3:0]    done;
    logic          dma_en;
    logic          dma_rdy;
    logic          dma_we;
    logic [31:0]   dma_addr;
    logic [5:0]    dma_len;
    logic          dma_done;
    logic          busy;
    logic          err;

    int vectors = 0;
    int miscompares = 0;

    dma_arbiter #(.NREQ(4), .AW(32), .LW(6), .TIMEOUT(20)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_len  (req_len),
        .gnt      (gnt),
        .done     (done),
        .dma_en   (dma_en),
        .dma_rdy  (dma_rdy),
        .dma_we   (dma_we),
        .dma_addr (dma_addr),
        .dma_len  (dma_len),
        .dma_done (dma_done),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_len = '0;
        dma_rdy = 1'b0; dma_done = 1'b0;
        tick(); tick();
        check("rst_gnt", 64'(gnt), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_dma_en", 64'(dma_en), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_dma_addr", 64'(dma_addr), 64'h0);
        check("rst_dma_len", 64'(dma_len), 64'h0);
        check("rst_dma_we", 64'(dma_we), 64'h0);
        rst = 1'b0;

        // Single request from requester 2, dropped after acceptance.
        req_addr[64 +: 32] = 32'h0029_0000;
        req_len[12 +: 6]   = 6'd16;
        req_we[2]          = 1'b1;
        req                = 4'b0100;
        dma_rdy            = 1'b1;
        tick();
        check("s_gnt", 64'(gnt), 64'h4);
        check("s_dma_en", 64'(dma_en), 64'h1);
        check("s_busy", 64'(busy), 64'h1);
        check("s_addr", 64'(dma_addr), 64'h0029_0000);
        check("s_len", 64'(dma_len), 64'd16);
        check("s_we", 64'(dma_we), 64'h1);
        tick();
        check("s_en_low", 64'(dma_en), 64'h0);
        check("s_gnt_hold", 64'(gnt), 64'h4);
        req = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("s_no_done", 64'(done), 64'h0);
            check("s_gnt_busy", 64'(gnt), 64'h4);
        end
        dma_done = 1'b1;
        tick();
        check("s_done", 64'(done), 64'h4);
        check("s_gnt_clr", 64'(gnt), 64'h0);
        check("s_busy_clr", 64'(busy), 64'h0);
        dma_done = 1'b0;
        tick();
        check("s_done_once", 64'(done), 64'h0);
        check("s_idle_gnt", 64'(gnt), 64'h0);

        // Round robin with all requesters held: order 0,1,2,3,0,1,2,3.
        rst = 1'b1; tick(); rst = 1'b0;
        req_we = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32] = 32'h1000_0000 + 32'(i) * 32'h100;
            req_len[i*6 +: 6]    = 6'(i + 1);
        end
        req = 4'b1111;
        dma_rdy = 1'b1;
        for (int b = 0; b < 8; b++) begin
            tick();
            check("rr_gnt", 64'(gnt), 64'(4'b0001 << (b % 4)));
            check("rr_en", 64'(dma_en), 64'h1);
            check("rr_addr", 64'(dma_addr), 64'(32'h1000_0000 + 32'(b % 4) * 32'h100));
            tick();
            check("rr_en_low", 64'(dma_en), 64'h0);
            dma_done = 1'b1;
            tick();
            check("rr_done", 64'(done), 64'(4'b0001 << (b % 4)));
            check("rr_idle_gnt", 64'(gnt), 64'h0);
            dma_done = 1'b0;
        end

        // Descriptor stall: dma_rdy low 10 cycles, late input changes and
        // an early dma_done must not disturb the issued descriptor.
        req = 4'b0001;
        dma_rdy = 1'b0;
        tick();
        check("st_gnt", 64'(gnt), 64'h1);
        check("st_en", 64'(dma_en), 64'h1);
        for (int c = 0; c < 10; c++) begin
            if (c == 1) req_addr[0 +: 32] = 32'hDEAD_0000;
            dma_done = (c == 4);
            tick();
            check("st_en_hold", 64'(dma_en), 64'h1);
            check("st_addr_hold", 64'(dma_addr), 64'h1000_0000);
            check("st_len_hold", 64'(dma_len), 64'd1);
            check("st_no_done", 64'(done), 64'h0);
        end
        dma_done = 1'b0;
        dma_rdy = 1'b1;
        tick();
        check("st_accept", 64'(dma_en), 64'h0);
        check("st_busy", 64'(busy), 64'h1);
        dma_done = 1'b1;
        tick();
        check("st_done", 64'(done), 64'h1);
        dma_done = 1'b0;
        req = 4'b0000;
        tick();

        // Zero-length burst from requester 1: no descriptor issued.
        req_len[6 +: 6] = 6'd0;
        req = 4'b0010;
        tick();
        check("z_gnt", 64'(gnt), 64'h2);
        check("z_en", 64'(dma_en), 64'h0);
        check("z_done_early", 64'(done), 64'h0);
        check("z_busy", 64'(busy), 64'h1);
        tick();
        check("z_done", 64'(done), 64'h2);
        check("z_gnt_clr", 64'(gnt), 64'h0);
        check("z_en2", 64'(dma_en), 64'h0);
        req = 4'b0000;
        tick();
        check("z_done_once", 64'(done), 64'h0);

        // Reset while BUSY: no done pulse, pointer returns to 0.
        req = 4'b1000;
        tick();
        check("r_gnt", 64'(gnt), 64'h8);
        tick();
        check("r_busy", 64'(busy), 64'h1);
        rst = 1'b1;
        dma_done = 1'b1;
        tick();
        check("r_gnt0", 64'(gnt), 64'h0);
        check("r_done0", 64'(done), 64'h0);
        check("r_busy0", 64'(busy), 64'h0);
        check("r_en0", 64'(dma_en), 64'h0);
        check("r_addr0", 64'(dma_addr), 64'h0);
        check("r_len0", 64'(dma_len), 64'h0);
        rst = 1'b0;
        dma_done = 1'b0;
        req = 4'b1111;
        tick();
        check("r_next_gnt", 64'(gnt), 64'h1);
        tick();
        dma_done = 1'b1;
        tick();
        check("r_done", 64'(done), 64'h1);
        dma_done = 1'b0;
        req = 4'b0000;
        tick();

`ifdef DMA_ARB_TIMEOUT_EN
        // Watchdog: no dma_done, err and done[2] 20 cycles after ISSUE entry.
        req = 4'b0100;
        tick();
        check("w_gnt", 64'(gnt), 64'h4);
        for (int t = 1; t < 20; t++) begin
            tick();
            check("w_no_err", 64'(err), 64'h0);
        end
        tick();
        check("w_err", 64'(err), 64'h1);
        check("w_done", 64'(done), 64'h4);
        check("w_gnt_clr", 64'(gnt), 64'h0);
        req = 4'b1111;
        tick();
        check("w_err_low", 64'(err), 64'h0);
        check("w_next_gnt", 64'(gnt), 64'h8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
